// File: rtl/protection_pkg.sv
// Shared types and constants for the protection cell sequencer.
package protection_pkg;

  localparam int unsigned SLW    = 3;          // slice width in bits
  localparam int unsigned NSLC   = 4;          // slices per frame
  localparam int unsigned PHASES = 4;          // cycles per slice
  localparam int unsigned FRW    = SLW * NSLC; // packed frame width (12)

  localparam logic [1:0] PH_LAST = 2'(PHASES - 1);
  localparam logic [1:0] SL_LAST = 2'(NSLC - 1);

  localparam logic [1:0] KEY_IDLE = 2'b00;
  localparam logic [1:0] KEY_RUN  = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter with a registered last-served pointer.
module rr_arb2 (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  input  logic REQ_A,
  input  logic REQ_B,
  input  logic UPD,
  input  logic UPD_OWN,
  output logic GNT_A,
  output logic GNT_B
);

  logic last_b;

  // Last-served pointer; resets to B so that A wins the first tie.
  always_ff @(posedge CLK) begin
    if (RST) begin
      last_b <= 1'b1;
    end else if (UPD) begin
      last_b <= UPD_OWN;
    end
  end

  // A lone requester wins outright; a tie goes to whoever was not served last.
  always_comb begin
    GNT_A = 1'b0;
    GNT_B = 1'b0;
    if (EN) begin
      if (REQ_A && REQ_B) begin
        GNT_A = last_b;
        GNT_B = !last_b;
      end else begin
        GNT_A = REQ_A;
        GNT_B = REQ_B;
      end
    end
  end

endmodule

// File: rtl/protection_sched.sv
// Sequencer/arbiter: accepts a word from A or B, feeds it to the protection
// cell one 3-bit slice per 4-cycle phase, then publishes the packed frame.
module protection_sched
  import protection_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        ENA,
  input  logic        REQ_A,
  input  logic [7:0]  RGA,
  output logic        GNT_A,
  input  logic        REQ_B,
  input  logic [7:0]  RGB,
  output logic        GNT_B,
  output logic [1:0]  KEY,
  output logic        SLD,
  output logic [2:0]  SLC,
  output logic [11:0] FRM,
  output logic        FRM_VLD,
  output logic        OWN,
  output logic [2:0]  CNT,
  output logic        BUSY
);

  state_t           state, nxt;
  logic [1:0]       phase;
  logic [1:0]       sidx;
  logic [FRW-1:0]   hold;
  logic [FRW-1:0]   frm_sr;
  logic [FRW-1:0]   frm_q;
  logic [2:0]       cnt;
  logic             own;
  logic             gnt_a, gnt_b;
  logic             arb_en, arb_upd;
  logic             sld;
  logic             frm_vld;
  logic [SLW-1:0]   slice;

  assign arb_en  = (state == IDLE) && ENA;
  assign arb_upd = (state == DONE) && ENA;
  assign slice   = hold[SLW*sidx +: SLW];

  rr_arb2 u_arb (
    .CLK     (CLK),
    .RST     (RST),
    .EN      (arb_en),
    .REQ_A   (REQ_A),
    .REQ_B   (REQ_B),
    .UPD     (arb_upd),
    .UPD_OWN (own),
    .GNT_A   (gnt_a),
    .GNT_B   (gnt_b)
  );

  // State register; ENA low freezes the sequencer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else if (ENA) begin
      state <= nxt;
    end
  end

  // Next-state and strobe decode; strobes are gated by ENA so a stall emits nothing.
  always_comb begin
    nxt     = state;
    KEY     = KEY_IDLE;
    sld     = 1'b0;
    frm_vld = 1'b0;
    unique case (state)
      IDLE: begin
        if (gnt_a || gnt_b) nxt = RUN;
      end
      RUN: begin
        KEY = KEY_RUN;
        if (ENA && (phase == PH_LAST)) begin
          sld = 1'b1;
          if (sidx == SL_LAST) nxt = DONE;
        end
      end
      DONE: begin
        if (ENA) begin
          frm_vld = 1'b1;
          nxt     = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Datapath: capture on grant, shift slices during RUN, publish frame in DONE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      phase  <= '0;
      sidx   <= '0;
      hold   <= '0;
      frm_sr <= '0;
      frm_q  <= '0;
      cnt    <= '0;
      own    <= 1'b0;
    end else if (ENA) begin
      unique case (state)
        IDLE: begin
          if (gnt_a || gnt_b) begin
            hold  <= {{(FRW-8){1'b0}}, (gnt_b ? RGB : RGA)};
            own   <= gnt_b;
            phase <= '0;
            sidx  <= '0;
          end
        end
        RUN: begin
          phase <= phase + 2'd1;
          if (sld) begin
            frm_sr <= {frm_sr[FRW-SLW-1:0], slice};
            sidx   <= sidx + 2'd1;
          end
        end
        DONE: begin
          frm_q <= frm_sr;
          cnt   <= cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // FRM shows the new frame in the same cycle as its FRM_VLD pulse, while the
  // registered copy (loaded at the end of DONE) keeps it stable afterwards.
  assign FRM     = frm_vld ? frm_sr : frm_q;
  assign FRM_VLD = frm_vld;
  assign SLD     = sld;
  assign SLC     = sld ? slice : '0;
  assign GNT_A   = gnt_a;
  assign GNT_B   = gnt_b;
  assign OWN     = own;
  assign CNT     = cnt;
  assign BUSY    = (state != IDLE);

endmodule

// File: doc/protection_sched.md
Name: protection_sched

Overview:
Sequencer and arbiter for the protection cell datapath. Two requesters (A, B) each offer 8-bit words, and a round-robin arbiter accepts one word at a time. The block splits the accepted word into 3-bit slices, one slice every 4-cycle phase. For each slice it drives KEY and a slice strobe into the protection cell, then packs the slices into a 12-bit frame and counts completed frames.

Parameters:
SLW, 3, slice width in bits
NSLC, 4, slices per frame (frame width = SLW*NSLC = 12)
PHASES, 4, cycles per slice (phase counter width = 2)

Ports:
CLK  in  1  clock, all logic on posedge
RST  in  1  synchronous, active-high reset
ENA  in  1  global enable; low = freeze all state
REQ_A  in  1  requester A has a word on RGA
RGA  in  8  requester A data, held stable while REQ_A=1
GNT_A  out  1  one-cycle accept for A
REQ_B  in  1  requester B has a word on RGB
RGB  in  8  requester B data, held stable while REQ_B=1
GNT_B  out  1  one-cycle accept for B
KEY  out  2  protection cell mode: 2'b00 idle/clear, 2'b01 run
SLD  out  1  slice load strobe (1 cycle)
SLC  out  3  slice value, valid while SLD=1
FRM  out  12  last completed packed frame
FRM_VLD  out  1  one-cycle pulse when FRM updates
OWN  out  1  owner of current/last frame (0=A, 1=B)
CNT  out  3  completed-frame counter, wraps mod 8
BUSY  out  1  high in any state other than IDLE

Behaviour:
- Reset (RST=1 at posedge, dominates ENA and any in-flight state). Resulting values:
  - state=IDLE; KEY=0, GNT_A=GNT_B=0, SLD=0, SLC=0, FRM=0, FRM_VLD=0, OWN=0, CNT=0, BUSY=0.
  - last-served pointer=B, so A wins the first tie.
  - Phase and slice counters = 0; hold register = 0.
- FSM states are IDLE, RUN, DONE.
- IDLE:
  - KEY=0.
  - When ENA=1 and REQ_A|REQ_B: the arbiter picks a requester and asserts that GNT in the same cycle (combinational from REQ and pointer). The selected RGx is captured into the 12-bit hold register, zero-extended. OWN is set, and the next state is RUN.
  - Tie rule: grant the requester not last served. A single requester always wins.
- RUN:
  - KEY=1. The 2-bit phase counter increments each ENA=1 cycle.
  - When phase==3: SLD=1 and SLC=hold[3k+2:3k] for slice index k (LSB slice first). FRM shift register <= {frm_sr[8:0], SLC}, and k increments.
  - After slice k=3 the next state is DONE.
- DONE (one cycle):
  - FRM <= frm_sr, FRM_VLD=1, CNT <= CNT+1 (7 wraps to 0).
  - Last-served pointer <= OWN. KEY=0. Next state is IDLE.
- Timing: accept at cycle G; slices at G+4, G+8, G+12, G+16; FRM_VLD at G+17. The earliest next GNT is G+18.
- ENA=0 in any state: FSM, counters, FRM and pointer hold. GNT, SLD and FRM_VLD are forced 0. KEY and BUSY hold.
- REQ asserted while BUSY is ignored, with no GNT. A requester dropping REQ before its grant is simply not granted, and no data is captured.
- FRM stays stable between FRM_VLD pulses. GNT_A and GNT_B are never high together.

Decomposition:
- Package protection_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - KEY_IDLE=2'b00 and KEY_RUN=2'b01;
  - SLW, NSLC, PHASES constants.
- One sub-module, rr_arb2: a two-input round-robin arbiter with registered last-served pointer and update-enable input. It outputs GNT_A/GNT_B.

Test Plan:
1. Reset: hold RST=1 during RUN (mid-frame) -> next cycle all outputs 0, BUSY=0, no FRM_VLD; then REQ_A alone is granted first.
2. Single frame A: REQ_A=1, RGA=8'hA5 at cycle G -> GNT_A at G; SLC = 5, 4, 2, 0 at G+4/8/12/16; FRM=12'hB10 with FRM_VLD at G+17; CNT=1; OWN=0.
3. Tie after reset: REQ_A=REQ_B=1, RGA=8'h01, RGB=8'hFF -> A first (FRM=12'h200), then B (FRM=12'hFD8, OWN=1); GNT_B at G+18; CNT=2.
4. ENA stall: drop ENA for 3 cycles during RUN after the second slice -> no SLD during the stall; remaining slices delayed by exactly 3 cycles; FRM_VLD at G+20 with the correct frame.
5. Counter wrap: run 9 back-to-back frames from A -> CNT goes 1..7, 0, 1; FRM_VLD count=9.
6. Request while busy: assert REQ_B at G+5 while A's frame runs -> no GNT_B until G+18; GNT_A and GNT_B are never simultaneous.
